// File: rtl/circ_wbuf.sv
// Double-buffered circular weight register: columns load into a shadow bank while the
// active bank rotates out to the MAC row. Define CIRC_WBUF_NEG_EN to add the saturated out_neg port.
module circ_wbuf #(
    parameter int DATA_W = 8,
    parameter int K_H    = 3,
    parameter int K_W    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [K_H-1:0][DATA_W-1:0]     in_data,
    input  logic                           swap,
    input  logic                           shift,
    output logic                           out_valid,
    output logic [K_H-1:0][DATA_W-1:0]     out_data,
`ifdef CIRC_WBUF_NEG_EN
    output logic [K_H-1:0][DATA_W-1:0]     out_neg,
`endif
    output logic                           rot_wrap,
    output logic                           shadow_full
);

    localparam int CW = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(K_W - 1);

    logic [DATA_W-1:0] r_active [K_H][K_W];
    logic [DATA_W-1:0] r_shadow [K_H][K_W];
    logic [CW-1:0]     r_col_cnt;
    logic [CW-1:0]     r_rot_ptr;
    logic              r_shadow_full;
    logic              r_active_valid;
    logic              r_rot_wrap;

    logic w_flush;
    logic w_accept;
    logic w_swap;
    logic w_shift;

    assign w_flush  = rst || clear;
    assign w_accept = in_valid && !r_shadow_full;
    assign w_swap   = swap && r_shadow_full;
    // A swap in the same cycle takes priority; the concurrent shift is dropped.
    assign w_shift  = shift && r_active_valid && !w_swap;

    // NOTE: both banks are reset because a flush must make out_data read back zero;
    // all sequential state below uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            for (int i = 0; i < K_H; i++) begin
                for (int j = 0; j < K_W; j++) begin
                    r_shadow[i][j] <= '0;
                end
            end
            r_col_cnt     <= '0;
            r_shadow_full <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < K_H; i++) begin
                    r_shadow[i][r_col_cnt] <= in_data[i];
                end
                if (r_col_cnt == LAST_COL) begin
                    r_col_cnt     <= '0;
                    r_shadow_full <= 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + 1'b1;
                end
            end else if (w_swap) begin
                r_shadow_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            for (int i = 0; i < K_H; i++) begin
                for (int j = 0; j < K_W; j++) begin
                    r_active[i][j] <= '0;
                end
            end
            r_rot_ptr      <= '0;
            r_active_valid <= 1'b0;
            r_rot_wrap     <= 1'b0;
        end else begin
            r_rot_wrap <= w_shift && (r_rot_ptr == LAST_COL);
            if (w_swap) begin
                r_active       <= r_shadow;
                r_active_valid <= 1'b1;
                r_rot_ptr      <= '0;
            end else if (w_shift) begin
                r_rot_ptr <= (r_rot_ptr == LAST_COL) ? '0 : r_rot_ptr + 1'b1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < K_H; i++) begin
            out_data[i] = r_active[i][r_rot_ptr];
        end
    end

`ifdef CIRC_WBUF_NEG_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    // -(-2^(DATA_W-1)) is not representable, so it saturates to the largest positive weight.
    always_comb begin
        out_neg = '0;
        for (int i = 0; i < K_H; i++) begin
            if (out_data[i] == MOST_NEG) begin
                out_neg[i] = MOST_POS;
            end else begin
                out_neg[i] = ~out_data[i] + DATA_W'(1);
            end
        end
    end
`endif

    assign in_ready    = !r_shadow_full;
    assign shadow_full = r_shadow_full;
    assign out_valid   = r_active_valid;
    assign rot_wrap    = r_rot_wrap;

endmodule

// File: tb/tb_circ_wbuf.sv
// Scoreboard bench for circ_wbuf: a queue/array reference model predicts each cycle's outputs
// and a monitor compares them one time step after every rising edge.
module tb_circ_wbuf;

    localparam int DATA_W = 8;
    localparam int K_H    = 3;
    localparam int K_W    = 3;

    typedef logic [K_H-1:0][DATA_W-1:0] col_t;

    typedef struct {
        logic ov;
        col_t od;
        col_t neg;
        logic wr;
        logic sf;
        logic ir;
    } exp_t;

    logic clk = 1'b0;
    logic rst, clear, in_valid, swap, shift;
    col_t in_data;
    logic in_ready, out_valid, rot_wrap, shadow_full;
    col_t out_data;
`ifdef CIRC_WBUF_NEG_EN
    col_t out_neg;
`endif

    circ_wbuf #(.DATA_W(DATA_W), .K_H(K_H), .K_W(K_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .swap       (swap),
        .shift      (shift),
        .out_valid  (out_valid),
        .out_data   (out_data),
`ifdef CIRC_WBUF_NEG_EN
        .out_neg    (out_neg),
`endif
        .rot_wrap   (rot_wrap),
        .shadow_full(shadow_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb [$];

    // Reference model: shadow is a queue of loaded columns, active a kernel read at index m_rot.
    col_t m_shadow [$];
    col_t m_active [K_W];
    int   m_rot   = 0;
    bit   m_av    = 0;
    bit   m_wrap  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic col_t negate(input col_t c);
        col_t r;
        for (int i = 0; i < K_H; i++) begin
            int x;
            int n;
            x = int'($signed(c[i]));
            n = (x == -(1 << (DATA_W - 1))) ? (1 << (DATA_W - 1)) - 1 : -x;
            r[i] = DATA_W'(n);
        end
        return r;
    endfunction

    function automatic col_t mk(input int a, input int b, input int c);
        col_t r;
        r[0] = DATA_W'(a);
        r[1] = DATA_W'(b);
        r[2] = DATA_W'(c);
        return r;
    endfunction

    // One clock cycle: drive inputs, advance the model, queue the expected post-edge outputs.
    task automatic cycle(input logic r, input logic c, input logic v, input col_t d,
                         input logic sw, input logic sh);
        bit full, acc, do_sw, do_sh;
        exp_t e;
        @(negedge clk);
        rst = r; clear = c; in_valid = v; in_data = d; swap = sw; shift = sh;
        if (r || c) begin
            m_shadow.delete();
            for (int j = 0; j < K_W; j++) m_active[j] = '0;
            m_rot = 0; m_av = 0; m_wrap = 0;
        end else begin
            full  = (m_shadow.size() == K_W);
            acc   = v && !full;
            do_sw = sw && full;
            do_sh = sh && m_av && !do_sw;
            m_wrap = do_sh && (m_rot == K_W - 1);
            if (do_sw) begin
                for (int j = 0; j < K_W; j++) m_active[j] = m_shadow[j];
                m_shadow.delete();
                m_av  = 1;
                m_rot = 0;
            end else if (do_sh) begin
                m_rot = (m_rot + 1) % K_W;
            end
            if (acc) m_shadow.push_back(d);
        end
        e.ov  = m_av;
        e.od  = m_active[m_rot];
        e.neg = negate(m_active[m_rot]);
        e.wr  = m_wrap;
        e.sf  = (m_shadow.size() == K_W);
        e.ir  = (m_shadow.size() != K_W);
        sb.push_back(e);
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, 0, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("out_valid",   64'(out_valid),   64'(e.ov));
            check("out_data",    64'(out_data),    64'(e.od));
            check("rot_wrap",    64'(rot_wrap),    64'(e.wr));
            check("shadow_full", 64'(shadow_full), 64'(e.sf));
            check("in_ready",    64'(in_ready),    64'(e.ir));
`ifdef CIRC_WBUF_NEG_EN
            check("out_neg",     64'(out_neg),     64'(e.neg));
`endif
        end
    end

    initial begin
        rst = 1; clear = 0; in_valid = 0; in_data = '0; swap = 0; shift = 0;
        cycle(1, 0, 0, '0, 0, 0);
        cycle(1, 0, 0, '0, 0, 0);

        // swap with empty shadow and shift with no active kernel change nothing
        cycle(0, 0, 0, '0, 1, 1);
        cycle(0, 0, 0, '0, 1, 0);

        // first kernel; in_valid stays high one extra cycle while shadow is full
        cycle(0, 0, 1, mk(1, 2, 3), 0, 0);
        cycle(0, 0, 1, mk(4, 5, 6), 0, 0);
        cycle(0, 0, 1, mk(7, 8, 9), 0, 0);
        cycle(0, 0, 1, mk(99, 99, 99), 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, '0, 0, 1);
        idle();

        // second kernel loads during rotation, then swap collides with shift
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, mk(10 + 3*k, 11 + 3*k, 12 + 3*k), 0, 1);
        cycle(0, 0, 0, '0, 1, 1);
        cycle(0, 0, 0, '0, 0, 1);

        // partial load discarded by clear; a fresh kernel with the most-negative weight follows
        cycle(0, 0, 1, mk(50, 51, 52), 0, 0);
        cycle(0, 0, 1, mk(53, 54, 55), 0, 0);
        cycle(0, 1, 0, '0, 0, 0);
        cycle(0, 0, 1, mk(-128, 5, 0), 0, 0);
        cycle(0, 0, 1, mk(127, -1, -127), 0, 0);
        cycle(0, 0, 1, mk(20, 21, 22), 0, 0);
        cycle(0, 0, 0, '0, 1, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, '0, 0, 1);

        // randomized traffic, with rare flushes
        for (int n = 0; n < 2000; n++) begin
            col_t d;
            for (int i = 0; i < K_H; i++) d[i] = DATA_W'($urandom);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0), d,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1));
        end
        idle();
        idle();

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
